riscv_regfile_sb: RTL and testbench
===================================

RISCV_REGFILE_SB -- requirements
Module: riscv_regfile_sb

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, meaning register data width in bits.
REQ-002 The block SHALL expose parameter NREG, default 32, meaning register count; legal values 16 (RV32E) or 32.
REQ-003 The block SHALL expose parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding enabled when 1.
REQ-004 The block SHALL derive local AW = $clog2(NREG) for all register address widths.
REQ-005 The block SHALL have port i_clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port i_rst, input, 1 bit, reset; asynchronous and active-high.
REQ-007 The block SHALL have port o_ready, output, 1 bit, high when the clear sweep is done and the block accepts traffic.
REQ-008 The block SHALL have ports i_rs1_addr and i_rs2_addr, input, AW bits each, read addresses.
REQ-009 The block SHALL have ports o_rs1_data and o_rs2_data, output, XLEN bits each, combinational read data.
REQ-010 The block SHALL have ports o_rs1_busy and o_rs2_busy, output, 1 bit each, scoreboard pending flag of the addressed register.
REQ-011 The block SHALL have ports i_rd_wen (1 bit), i_rd_addr (AW bits) and i_rd_data (XLEN bits), all inputs, forming the writeback port.
REQ-012 The block SHALL have ports i_iss_wen (1 bit) and i_iss_addr (AW bits), both inputs, forming the issue port that marks a destination pending.

Function
REQ-013 The block SHALL implement a two-state FSM: CLEAR and RUN.
REQ-014 In CLEAR the block SHALL zero one register per cycle, index 1 up to NREG-1, using an AW-bit sweep counter.
REQ-015 CLEAR SHALL last exactly NREG-1 cycles; after zeroing index NREG-1 the FSM SHALL move to RUN, and o_ready SHALL rise on that next edge.
REQ-016 In CLEAR the block SHALL ignore i_rd_wen and i_iss_wen, force o_rs1_data and o_rs2_data to 0, and force both busy outputs to 0.
REQ-017 RUN SHALL be terminal; the FSM leaves RUN only through reset.
REQ-018 Register x0 SHALL read 0 at all times; writes and issues addressed to x0 SHALL be discarded.
REQ-019 In RUN, i_rd_wen=1 with i_rd_addr!=0 SHALL write i_rd_data on the rising edge and SHALL clear busy[i_rd_addr].
REQ-020 In RUN, i_iss_wen=1 with i_iss_addr!=0 SHALL set busy[i_iss_addr] on the rising edge.
REQ-021 A same-cycle issue and writeback to the same register SHALL leave busy set (issue wins) while the data is still written.
REQ-022 With BYPASS=1, a read whose address equals a same-cycle valid writeback address (nonzero) SHALL return i_rd_data, and its busy output SHALL read 0 unless i_iss_wen targets the same register that cycle.
REQ-023 With BYPASS=0, reads SHALL return the pre-edge register value, and busy SHALL reflect the stored flag only.
REQ-024 Reads SHALL have zero-cycle latency (combinational from address); writes SHALL become visible without bypass one cycle later.
REQ-025 When NREG=16, only addresses 0..15 SHALL be representable (AW=4); no wrap or alias logic is required.

Reset
REQ-026 Asserting i_rst SHALL immediately set the FSM to CLEAR, the sweep counter to 1, o_ready to 0, and all busy flags to 0, independent of the clock.
REQ-027 Register contents SHALL NOT be reset asynchronously; they SHALL be zeroed by the CLEAR sweep only.
REQ-028 Reset asserted mid-sweep or mid-RUN SHALL restart the full CLEAR sweep from index 1 after deassertion.
REQ-029 Writes and issues presented in the cycle of reset deassertion SHALL be ignored.

Verification
REQ-030 The bench SHALL apply reset, then count cycles -> o_ready SHALL rise exactly NREG-1 cycles after deassertion (31 for the default), and every read SHALL return 0.
REQ-031 The bench SHALL write x5=0x1234_5678 in RUN, then read rs1=5 the next cycle -> result SHALL be 0x1234_5678; write x0=0xFFFF_FFFF then read rs2=0 -> result SHALL be 0.
REQ-032 With BYPASS=1, the bench SHALL write x7=0xA5A5_A5A5 while reading rs1=7 in the same cycle -> o_rs1_data SHALL be 0xA5A5_A5A5 that cycle; the same test with BYPASS=0 -> SHALL return the old value.
REQ-033 The bench SHALL issue x9, then observe -> o_rs1_busy=1 for rs1=9; writeback of x9 -> busy SHALL be 0 the next cycle; simultaneous issue and writeback of x9 -> busy SHALL stay 1.
REQ-034 The bench SHALL fill x1..x31 with random values, then assert reset mid-RUN and re-sweep -> all registers SHALL read 0 after o_ready, and all busy flags SHALL be 0.
REQ-035 The bench SHALL repeat REQ-030 and REQ-031 with NREG=16 -> o_ready SHALL rise after 15 cycles and x15 SHALL read and write correctly.

Source files
------------

// File: rtl/riscv_regfile_sb.sv
// RISC-V integer register file with a per-register scoreboard (busy) bit.
// After reset a sweep zeroes x1..x(NREG-1), one per cycle, before traffic is accepted.
module riscv_regfile_sb #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREG   = 32,
   parameter bit          BYPASS = 1'b1,
   localparam int unsigned AW    = $clog2(NREG)
) (
   input  logic            i_clk,
   input  logic            i_rst,
   output logic            o_ready,
   input  logic [AW-1:0]   i_rs1_addr,
   input  logic [AW-1:0]   i_rs2_addr,
   output logic [XLEN-1:0] o_rs1_data,
   output logic [XLEN-1:0] o_rs2_data,
   output logic            o_rs1_busy,
   output logic            o_rs2_busy,
   input  logic            i_rd_wen,
   input  logic [AW-1:0]   i_rd_addr,
   input  logic [XLEN-1:0] i_rd_data,
   input  logic            i_iss_wen,
   input  logic [AW-1:0]   i_iss_addr
);

   typedef enum logic {StClear, StRun} state_e;

   state_e            state_q, state_d;
   logic [AW-1:0]     sweep_q, sweep_d;
   logic [NREG-1:0]   busy_q, busy_d;
   logic [XLEN-1:0]   regs_q [NREG];
   logic              clr_en;
   logic              run;
   logic              wr_en;
   logic              iss_en;
   logic              fwd1, fwd2;

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      clr_en  = 1'b0;
      unique case (state_q)
         StClear: begin
            clr_en  = 1'b1;
            sweep_d = sweep_q + AW'(1);
            if (sweep_q == AW'(NREG - 1)) state_d = StRun;
         end
         StRun: ;
         default: state_d = StClear;
      endcase
   end

   assign run     = (state_q == StRun);
   assign o_ready = run;
   assign wr_en   = run && i_rd_wen && (i_rd_addr != '0);
   assign iss_en  = run && i_iss_wen && (i_iss_addr != '0);

   // Issue is applied after writeback so a same-cycle pair leaves the register pending.
   always_comb begin
      busy_d = busy_q;
      if (wr_en)  busy_d[i_rd_addr]  = 1'b0;
      if (iss_en) busy_d[i_iss_addr] = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StClear;
         sweep_q <= AW'(1);
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
         busy_q  <= busy_d;
      end
   end

   // Storage has no reset; contents are only cleared by the sweep.
   always_ff @(posedge i_clk) begin
      if (clr_en) begin
         regs_q[sweep_q] <= '0;
      end else if (wr_en) begin
         regs_q[i_rd_addr] <= i_rd_data;
      end
   end

   assign fwd1 = BYPASS && wr_en && (i_rs1_addr == i_rd_addr);
   assign fwd2 = BYPASS && wr_en && (i_rs2_addr == i_rd_addr);

   always_comb begin
      o_rs1_data = '0;
      o_rs1_busy = 1'b0;
      if (run && (i_rs1_addr != '0)) begin
         if (fwd1) begin
            o_rs1_data = i_rd_data;
            o_rs1_busy = iss_en && (i_iss_addr == i_rs1_addr);
         end else begin
            o_rs1_data = regs_q[i_rs1_addr];
            o_rs1_busy = busy_q[i_rs1_addr];
         end
      end
   end

   always_comb begin
      o_rs2_data = '0;
      o_rs2_busy = 1'b0;
      if (run && (i_rs2_addr != '0)) begin
         if (fwd2) begin
            o_rs2_data = i_rd_data;
            o_rs2_busy = iss_en && (i_iss_addr == i_rs2_addr);
         end else begin
            o_rs2_data = regs_q[i_rs2_addr];
            o_rs2_busy = busy_q[i_rs2_addr];
         end
      end
   end

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Directed bench for riscv_regfile_sb: default, no-bypass and 16-register instances
// share one stimulus stream and are each checked against hand-computed values.
module tb_riscv_regfile_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr, iss_addr;
   logic [31:0] rd_data;
   logic        rd_wen, iss_wen;

   logic        rdy, b1, b2;
   logic [31:0] d1, d2;
   logic        nb_rdy, nb_b1, nb_b2;
   logic [31:0] nb_d1, nb_d2;
   logic        s_rdy, s_b1, s_b2;
   logic [31:0] s_d1, s_d2;

   int          n_vec = 0;
   int          n_err = 0;
   int          c32, cnb, c16;
   logic [31:0] model [32];

   always #5 clk = ~clk;

   riscv_regfile_sb dut (
      .i_clk(clk), .i_rst(rst), .o_ready(rdy),
      .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
      .o_rs1_data(d1), .o_rs2_data(d2), .o_rs1_busy(b1), .o_rs2_busy(b2),
      .i_rd_wen(rd_wen), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
      .i_iss_wen(iss_wen), .i_iss_addr(iss_addr)
   );

   riscv_regfile_sb #(.BYPASS(1'b0)) dut_nb (
      .i_clk(clk), .i_rst(rst), .o_ready(nb_rdy),
      .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
      .o_rs1_data(nb_d1), .o_rs2_data(nb_d2), .o_rs1_busy(nb_b1), .o_rs2_busy(nb_b2),
      .i_rd_wen(rd_wen), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
      .i_iss_wen(iss_wen), .i_iss_addr(iss_addr)
   );

   riscv_regfile_sb #(.NREG(16)) dut16 (
      .i_clk(clk), .i_rst(rst), .o_ready(s_rdy),
      .i_rs1_addr(rs1_addr[3:0]), .i_rs2_addr(rs2_addr[3:0]),
      .o_rs1_data(s_d1), .o_rs2_data(s_d2), .o_rs1_busy(s_b1), .o_rs2_busy(s_b2),
      .i_rd_wen(rd_wen), .i_rd_addr(rd_addr[3:0]), .i_rd_data(rd_data),
      .i_iss_wen(iss_wen), .i_iss_addr(iss_addr[3:0])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Count edges after reset release until each instance is ready; 0 means timed out.
   task automatic sweep(output int c_main, output int c_nb, output int c_16);
      c_main = 0;
      c_nb   = 0;
      c_16   = 0;
      for (int k = 1; k <= 100 && (c_main == 0 || c_nb == 0); k++) begin
         step();
         if (k == 1) begin
            rd_wen  = 1'b0;
            iss_wen = 1'b0;
         end
         if (rdy    && c_main == 0) c_main = k;
         if (nb_rdy && c_nb   == 0) c_nb   = k;
         if (s_rdy  && c_16   == 0) c_16   = k;
      end
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] v);
      rd_wen  = 1'b1;
      rd_addr = a;
      rd_data = v;
      step();
      rd_wen  = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(31 - i);
         #1;
         check_eq({tag, "_d1"}, d1, 32'h0);
         check_eq({tag, "_d2"}, d2, 32'h0);
         check_eq({tag, "_busy"}, {30'h0, b1, b2}, 32'h0);
         check_eq({tag, "_nb_d1"}, nb_d1, 32'h0);
         if (i < 16) begin
            check_eq({tag, "_s_d1"}, s_d1, 32'h0);
            check_eq({tag, "_s_busy"}, {31'h0, s_b1}, 32'h0);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      {rs1_addr, rs2_addr, rd_addr, iss_addr} = '0;
      rd_data = '0;
      rd_wen  = 1'b0;
      iss_wen = 1'b0;
      repeat (3) step();
      check_eq("reset_ready", {29'h0, rdy, nb_rdy, s_rdy}, 32'h0);

      // Traffic in the release cycle must be dropped.
      rd_wen   = 1'b1; rd_addr  = 5'd3; rd_data = 32'hBAD0_BAD0;
      iss_wen  = 1'b1; iss_addr = 5'd3;
      rst = 1'b0;
      sweep(c32, cnb, c16);
      check_eq("ready_lat32", c32, 32'd31);
      check_eq("ready_lat_nb", cnb, 32'd31);
      check_eq("ready_lat16", c16, 32'd15);
      check_all_zero("post_sweep");

      // Basic write then read next cycle, and x0 discard.
      write_reg(5'd5, 32'h1234_5678);
      rs1_addr = 5'd5; #1;
      check_eq("x5_rd", d1, 32'h1234_5678);
      check_eq("x5_rd_nb", nb_d1, 32'h1234_5678);
      check_eq("x5_rd16", s_d1, 32'h1234_5678);
      write_reg(5'd0, 32'hFFFF_FFFF);
      rs2_addr = 5'd0; #1;
      check_eq("x0_rd", d2, 32'h0);
      check_eq("x0_rd16", s_d2, 32'h0);

      write_reg(5'd15, 32'hDEAD_BEEF);
      rs1_addr = 5'd15; #1;
      check_eq("x15_rd", d1, 32'hDEAD_BEEF);
      check_eq("x15_rd16", s_d1, 32'hDEAD_BEEF);

      // Same-cycle write/read forwarding.
      write_reg(5'd7, 32'h1111_1111);
      rd_wen = 1'b1; rd_addr = 5'd7; rd_data = 32'hA5A5_A5A5; rs1_addr = 5'd7;
      #1;
      check_eq("byp_rd", d1, 32'hA5A5_A5A5);
      check_eq("nobyp_rd", nb_d1, 32'h1111_1111);
      step();
      rd_wen = 1'b0; #1;
      check_eq("nobyp_rd_after", nb_d1, 32'hA5A5_A5A5);

      // Scoreboard.
      iss_wen = 1'b1; iss_addr = 5'd9; rs1_addr = 5'd9; #1;
      check_eq("busy_pre_edge", {31'h0, b1}, 32'h0);
      step();
      iss_wen = 1'b0; #1;
      check_eq("busy_set", {31'h0, b1}, 32'h1);
      check_eq("busy_set_nb", {31'h0, nb_b1}, 32'h1);
      rd_wen = 1'b1; rd_addr = 5'd9; rd_data = 32'h0000_0042; #1;
      check_eq("busy_byp_wb", {31'h0, b1}, 32'h0);
      check_eq("busy_nobyp_wb", {31'h0, nb_b1}, 32'h1);
      step();
      rd_wen = 1'b0; #1;
      check_eq("busy_clr", {31'h0, b1}, 32'h0);
      check_eq("busy_clr_nb", {31'h0, nb_b1}, 32'h0);
      rd_wen = 1'b1; rd_data = 32'h0000_0099; iss_wen = 1'b1; #1;
      check_eq("busy_byp_both", {31'h0, b1}, 32'h1);
      check_eq("data_byp_both", d1, 32'h0000_0099);
      step();
      rd_wen = 1'b0; iss_wen = 1'b0; #1;
      check_eq("busy_both", {31'h0, b1}, 32'h1);
      check_eq("data_both", d1, 32'h0000_0099);
      check_eq("busy_both_nb", {31'h0, nb_b1}, 32'h1);
      iss_wen = 1'b1; iss_addr = 5'd0; step();
      iss_wen = 1'b0; rs2_addr = 5'd0; #1;
      check_eq("busy_x0", {31'h0, b2}, 32'h0);

      // Fill, check, then reset mid-run.
      model[0] = '0;
      for (int i = 1; i < 32; i++) begin
         model[i] = $urandom;
         write_reg(5'(i), model[i]);
      end
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i); #1;
         check_eq("fill_rd", d1, model[i]);
      end
      iss_wen = 1'b1; iss_addr = 5'd12; step();
      iss_wen = 1'b0; rs1_addr = 5'd12; #1;
      check_eq("busy12", {31'h0, b1}, 32'h1);
      rst = 1'b1; #1;
      check_eq("async_rst_ready", {31'h0, rdy}, 32'h0);
      check_eq("async_rst_busy", {31'h0, b1}, 32'h0);
      step();
      rst = 1'b0;
      // Interrupt the sweep partway and restart it.
      repeat (10) step();
      check_eq("mid_sweep_ready", {31'h0, rdy}, 32'h0);
      rst = 1'b1; step();
      rst = 1'b0;
      sweep(c32, cnb, c16);
      check_eq("resweep_lat32", c32, 32'd31);
      check_eq("resweep_lat16", c16, 32'd15);
      check_all_zero("resweep");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
